// File: rtl/fir_pkg.sv
// Shared FIR package: loader FSM state encoding and default geometry,
// used by fir_coeff_loader and fir_filter.
package fir_pkg;

   localparam int FIR_NUM_TAPS = 71;
   localparam int FIR_COEFF_W  = 8;
   localparam int FIR_ADDR_W   = 7;

   // CHECK is only reachable when FIR_COEFF_CHECKSUM_EN is defined; the
   // encoding stays fixed so both builds decode state identically.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } fir_state_e;

   // True when the tap index is the final tap of a load.
   function automatic logic fir_is_last_tap(input int unsigned tap,
                                            input int unsigned num_taps);
      return (tap == num_taps - 1);
   endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// FIR coefficient loader: accepts NUM_TAPS coefficients from a host
// valid/ready stream and writes them, tap 0 first, into the FIR
// coefficient memory one cycle after each accepted beat.
// Optional build macro FIR_COEFF_CHECKSUM_EN adds a trailing checksum
// beat (modulo-2**COEFF_W sum of the coefficients) and the error flag.
module fir_coeff_loader
   import fir_pkg::*;
#(
   parameter int NUM_TAPS = FIR_NUM_TAPS,
   parameter int COEFF_W  = FIR_COEFF_W,
   parameter int ADDR_W   = FIR_ADDR_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               host_valid,
   input  logic [COEFF_W-1:0] host_data,
   output logic               host_ready,
   output logic               coeff_write,
   output logic [ADDR_W-1:0]  coeff_addr,
   output logic [COEFF_W-1:0] coeff_in,
   output logic               busy,
   output logic               done,
   output logic               error
);

   // Every tap must be addressable.
   if (NUM_TAPS > (2 ** ADDR_W)) begin : g_bad_cfg
      $error("fir_coeff_loader: NUM_TAPS exceeds 2**ADDR_W");
   end

   localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

   fir_state_e         state_q, state_d;
   logic [ADDR_W-1:0]  tap_q,   tap_d;
   logic               wr_q,    wr_d;
   logic [ADDR_W-1:0]  addr_q,  addr_d;
   logic [COEFF_W-1:0] data_q,  data_d;
`ifdef FIR_COEFF_CHECKSUM_EN
   logic [COEFF_W-1:0] sum_q,   sum_d;
   logic               err_q,   err_d;
`endif

   logic beat;
   logic last_tap;

   // Handshake and status decode straight from state so reset clears them
   // without waiting for a clock.
   always_comb begin
      host_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
      busy       = (state_q != ST_IDLE);
      done       = (state_q == ST_DONE);
      beat       = host_valid & host_ready;
      last_tap   = (tap_q == LAST_TAP);
   end

   // Next-state, tap counter and write-port update.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      wr_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
`ifdef FIR_COEFF_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_LOAD;
               tap_d   = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            // Abort wins over any beat in the same cycle, including the last.
            if (abort) begin
               state_d = ST_IDLE;
               tap_d   = '0;
            end else if (beat) begin
               wr_d   = 1'b1;
               addr_d = tap_q;
               data_d = host_data;
`ifdef FIR_COEFF_CHECKSUM_EN
               sum_d  = sum_q + host_data;
`endif
               if (last_tap) begin
                  tap_d = '0;
`ifdef FIR_COEFF_CHECKSUM_EN
                  state_d = ST_CHECK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  tap_d = tap_q + 1'b1;
               end
            end
         end
         ST_CHECK: begin
`ifdef FIR_COEFF_CHECKSUM_EN
            // The checksum beat is consumed here and never reaches the FIR.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (beat) begin
               if (host_data == sum_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
`else
            state_d = ST_IDLE;
`endif
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counter and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         tap_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

`ifdef FIR_COEFF_CHECKSUM_EN
   // Running checksum and sticky error flag (cleared by the next start).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         err_q <= 1'b0;
      end else begin
         sum_q <= sum_d;
         err_q <= err_d;
      end
   end

   // Drive the error output from the sticky flag.
   always_comb begin
      error = err_q;
   end
`else
   // No checksum support: error can never be raised.
   always_comb begin
      error = 1'b0;
   end
`endif

   // Drive the memory write port from its registers.
   always_comb begin
      coeff_write = wr_q;
      coeff_addr  = addr_q;
      coeff_in    = data_q;
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: every accepted beat pushes the
// expected (address, data) write; a monitor pops and compares each write.
module tb_fir_coeff_loader;

   localparam int NT = 71;
   localparam int CW = 8;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic          host_valid = 1'b0;
   logic [CW-1:0] host_data = '0;
   logic          host_ready;
   logic          coeff_write;
   logic [AW-1:0] coeff_addr;
   logic [CW-1:0] coeff_in;
   logic          busy;
   logic          done;
   logic          error;

   fir_coeff_loader #(.NUM_TAPS(NT), .COEFF_W(CW), .ADDR_W(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
      .coeff_write(coeff_write), .coeff_addr(coeff_addr), .coeff_in(coeff_in),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [CW-1:0] d;
   } wr_t;

   wr_t           exp_q[$];
   wr_t           e;
   int            n_chk = 0;
   int            n_fail = 0;
   int            wr_cnt = 0;
   int            done_cnt = 0;
   int            cyc = 0;
   int            done_cyc = -1;
   int            last_wr_cyc = -2;
   logic [AW-1:0] last_addr = '0;
   logic [CW-1:0] s;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: sample registered outputs just after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (coeff_write) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(coeff_addr), 32'hffff);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(coeff_addr), 32'(e.a));
            chk("wr_data", 32'(coeff_in), 32'(e.d));
         end
         wr_cnt++;
         last_addr   = coeff_addr;
         last_wr_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic clr();
      wr_cnt   = 0;
      done_cnt = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_rdy"},   32'(host_ready), 0);
      chk({tag, "_wr"},    32'(coeff_write), 0);
      chk({tag, "_addr"},  32'(coeff_addr), 0);
      chk({tag, "_data"},  32'(coeff_in), 0);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_error"}, 32'(error), 0);
   endtask

   // Called at a negedge in IDLE. mode: 0 stream, 1 valid toggling with
   // random data, 2 abort at beat cut_at, 3 reset at beat cut_at,
   // 4 stray start pulses during LOAD.
   task automatic load(input int mode, input int cut_at, output logic [CW-1:0] sum);
      int k = 0;
      int t = 0;
      sum   = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (k < NT && t < 2000) begin
         host_valid = (mode == 1) ? (t % 2 == 0) : 1'b1;
         host_data  = (mode == 1) ? CW'($urandom_range(0, 255)) : CW'(k);
         start      = (mode == 4) && (t % 9 == 4);
         abort      = (mode == 2) && (k == cut_at);
         if (mode == 3 && k == cut_at) begin
            #2 rst_n = 1'b0;
            #1;
            chk_all_zero("midreset");
            exp_q.delete();
            host_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         if (abort) begin
            @(negedge clk);
            abort      = 1'b0;
            host_valid = 1'b0;
            chk("abort_busy", 32'(busy), 0);
            return;
         end
         if (host_valid && host_ready) begin
            exp_q.push_back('{a: AW'(k), d: host_data});
            sum = sum + host_data;
            k++;
         end
         @(negedge clk);
         t++;
      end
      host_valid = 1'b0;
      start      = 1'b0;
      if (t >= 2000) chk("load_timeout", 0, 1);
   endtask

   // Called at the negedge after the final beat; ends at the IDLE negedge.
   task automatic fin(input logic [CW-1:0] csum, input bit ok);
`ifdef FIR_COEFF_CHECKSUM_EN
      chk("check_rdy", 32'(host_ready), 1);
      host_valid = 1'b1;
      host_data  = csum;
      @(negedge clk);
      host_valid = 1'b0;
      chk("check_done", 32'(done), 32'(ok));
      chk("check_error", 32'(error), 32'(!ok));
`else
      chk("rdy_drop", 32'(host_ready), 0);
      chk("done_pulse", 32'(done), 1);
      chk("error_tied", 32'(error), 0);
      chk("done_unused_args", 32'(ok), 1);
      host_data = csum;
`endif
      @(negedge clk);
      chk("back_idle", 32'(busy), 0);
      chk("done_one_cycle", 32'(done), 0);
   endtask

   task automatic full_counts(input string tag);
      chk({tag, "_writes"}, 32'(wr_cnt), NT);
      chk({tag, "_dones"}, 32'(done_cnt), 1);
      chk({tag, "_last_addr"}, 32'(last_addr), NT - 1);
   endtask

   initial begin
      #3;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Continuous stream 0..70.
      clr();
      load(0, 0, s);
      fin(s, 1'b1);
      full_counts("stream");
`ifndef FIR_COEFF_CHECKSUM_EN
      chk("done_after_last_beat", 32'(done_cyc), 32'(last_wr_cyc));
`endif

      // Back-to-back: start in the IDLE cycle right after DONE, toggling valid.
      clr();
      load(1, 0, s);
      fin(s, 1'b1);
      full_counts("toggle");

      // Stray start during LOAD is ignored.
      clr();
      load(4, 0, s);
      fin(s, 1'b1);
      full_counts("start_mid");

      // Abort coincident with beat 30.
      clr();
      load(2, 30, s);
      repeat (3) @(negedge clk);
      chk("abort_writes", 32'(wr_cnt), 30);
      chk("abort_last_addr", 32'(last_addr), 29);
      chk("abort_no_done", 32'(done_cnt), 0);

      // Reset at beat 40, then a fresh load from address 0.
      clr();
      load(3, 40, s);
      chk("reset_writes", 32'(wr_cnt), 40);
      @(negedge clk);
      clr();
      load(0, 0, s);
      fin(s, 1'b1);
      full_counts("reload");

`ifdef FIR_COEFF_CHECKSUM_EN
      // Wrong checksum: error raised and held, no done.
      clr();
      load(0, 0, s);
      fin(s + 8'd1, 1'b0);
      repeat (2) @(negedge clk);
      chk("error_held", 32'(error), 1);
      chk("bad_sum_no_done", 32'(done_cnt), 0);
      // Next start clears the flag; good checksum completes.
      clr();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("error_cleared", 32'(error), 0);
      chk("restart_busy", 32'(busy), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      clr();
      load(0, 0, s);
      fin(s, 1'b1);
      full_counts("good_sum");
`endif

      chk("scoreboard_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
